// File: rtl/ex_forward_ctrl_if.sv
// Bus between the ID/EX pipeline register logic and the EX forwarding/hazard
// controller. The ID side drives the instruction descriptor and control
// inputs; the controller drives mux selects, stall/bubble and debug state.
//
// Qualifier semantics: the ID descriptor (rs/rt/rd/use/regwrite/memread) is
// only meaningful while i_id_valid is 1. i_flush squashes it even when valid.
// There is no back-pressure from the controller other than o_stall, which
// tells the front end to hold PC and IF/ID for that cycle.
interface ex_forward_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              i_halt;
  logic              i_flush;
  logic              i_id_valid;
  logic [REG_AW-1:0] i_id_rs;
  logic [REG_AW-1:0] i_id_rt;
  logic              i_id_use_rs;
  logic              i_id_use_rt;
  logic [REG_AW-1:0] i_id_rd;
  logic              i_id_regwrite;
  logic              i_id_memread;

  logic [1:0]        o_fwd_a;
  logic [1:0]        o_fwd_b;
  logic              o_stall;
  logic              o_bubble;
  logic [CNT_W-1:0]  o_stall_count;

  // Debug visibility: FSM state (0 = RUN, 1 = LU_STALL) and the WB shadow.
  logic              dbg_state;
  logic [REG_AW-1:0] dbg_wb_rd;
  logic              dbg_wb_regwrite;

  modport master (
    output i_halt, i_flush, i_id_valid, i_id_rs, i_id_rt, i_id_use_rs,
           i_id_use_rt, i_id_rd, i_id_regwrite, i_id_memread,
    input  o_fwd_a, o_fwd_b, o_stall, o_bubble, o_stall_count,
           dbg_state, dbg_wb_rd, dbg_wb_regwrite
  );

  modport slave (
    input  i_halt, i_flush, i_id_valid, i_id_rs, i_id_rt, i_id_use_rs,
           i_id_use_rt, i_id_rd, i_id_regwrite, i_id_memread,
    output o_fwd_a, o_fwd_b, o_stall, o_bubble, o_stall_count,
           dbg_state, dbg_wb_rd, dbg_wb_regwrite
  );
endinterface

// File: rtl/ex_forward_ctrl.sv
// EX-stage forwarding and load-use hazard controller. Shadows destination
// info for EX/MEM/WB, produces registered operand-mux selects that travel
// with the instruction into EX, and inserts a single-cycle stall + bubble
// when an instruction in ID needs the result of a load sitting in EX.
module ex_forward_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          reset,
  ex_forward_ctrl_if.slave bus
);

  typedef enum logic {RUN = 1'b0, LU_STALL = 1'b1} state_e;

  state_e            state_q, state_d;

  logic [REG_AW-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
  logic              ex_rw_q, mem_rw_q, wb_rw_q;
  logic              ex_mr_q;
  logic [1:0]        fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              hz;
  logic              stall;
  logic              entry_bubble;
  logic [1:0]        sel_a, sel_b;

  // Nearest producer wins: EX (becomes EX/MEM) before MEM (becomes MEM/WB).
  function automatic logic [1:0] fwd_sel(
    input logic              use_s,
    input logic [REG_AW-1:0] s,
    input logic              ex_rw,
    input logic [REG_AW-1:0] ex_rd,
    input logic              mem_rw,
    input logic [REG_AW-1:0] mem_rd
  );
    logic [1:0] r;
    r = 2'b00;
    if (use_s && (s != '0)) begin
      if (ex_rw && (ex_rd == s))        r = 2'b10;
      else if (mem_rw && (mem_rd == s)) r = 2'b01;
    end
    return r;
  endfunction

  // Load-use detection against the load currently in EX.
  always_comb begin
    hz = bus.i_id_valid && !bus.i_flush && ex_mr_q && ex_rw_q && (ex_rd_q != '0) &&
         ((bus.i_id_use_rs && (bus.i_id_rs == ex_rd_q)) ||
          (bus.i_id_use_rt && (bus.i_id_rt == ex_rd_q)));
  end

  // FSM state register; halt freezes it, reset beats halt.
  always_ff @(posedge clk) begin
    if (reset)            state_q <= RUN;
    else if (!bus.i_halt) state_q <= state_d;
  end

  // FSM next state: one stall per load, then back to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (hz && !bus.i_halt) state_d = LU_STALL;
      LU_STALL: state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // FSM outputs: stall and bubble only from RUN and never while halted.
  always_comb begin
    stall = hz && !bus.i_halt && (state_q == RUN);
  end

  // ID entry into the shadow pipe and the selects it will carry into EX.
  always_comb begin
    entry_bubble = stall || bus.i_flush || !bus.i_id_valid;
    sel_a = 2'b00;
    sel_b = 2'b00;
    if (!entry_bubble) begin
      sel_a = fwd_sel(bus.i_id_use_rs, bus.i_id_rs, ex_rw_q, ex_rd_q, mem_rw_q, mem_rd_q);
      sel_b = fwd_sel(bus.i_id_use_rt, bus.i_id_rt, ex_rw_q, ex_rd_q, mem_rw_q, mem_rd_q);
    end
  end

  // Shadow pipe, registered selects and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rd_q  <= '0;
      ex_rw_q  <= 1'b0;
      ex_mr_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_rw_q <= 1'b0;
      wb_rd_q  <= '0;
      wb_rw_q  <= 1'b0;
      fwd_a_q  <= 2'b00;
      fwd_b_q  <= 2'b00;
      cnt_q    <= '0;
    end else if (!bus.i_halt) begin
      wb_rd_q  <= mem_rd_q;
      wb_rw_q  <= mem_rw_q;
      mem_rd_q <= ex_rd_q;
      mem_rw_q <= ex_rw_q;
      ex_rd_q  <= entry_bubble ? '0 : bus.i_id_rd;
      ex_rw_q  <= entry_bubble ? 1'b0 : bus.i_id_regwrite;
      ex_mr_q  <= entry_bubble ? 1'b0 : bus.i_id_memread;
      fwd_a_q  <= sel_a;
      fwd_b_q  <= sel_b;
      if (stall && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Output drive.
  always_comb begin
    bus.o_fwd_a         = fwd_a_q;
    bus.o_fwd_b         = fwd_b_q;
    bus.o_stall         = stall;
    bus.o_bubble        = stall;
    bus.o_stall_count   = cnt_q;
    bus.dbg_state       = state_q;
    bus.dbg_wb_rd       = wb_rd_q;
    bus.dbg_wb_regwrite = wb_rw_q;
  end

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Bench for ex_forward_ctrl: directed pipeline scenarios with literal
// expectations, then randomized traffic, all checked every cycle against an
// instruction-level model of the pipeline.
module tb_ex_forward_ctrl;
  localparam int AW   = 5;
  localparam int CW   = 3;
  localparam int W    = 4 + CW;
  localparam int CMAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_forward_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();
  ex_forward_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (.clk(clk), .reset(rst), .bus(bus));

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input int rs, input int rt, input bit urs, input bit urt,
                        input int rd, input bit rw, input bit mr);
    bus.i_id_valid    = 1'b1;
    bus.i_id_rs       = AW'(rs);
    bus.i_id_rt       = AW'(rt);
    bus.i_id_use_rs   = urs;
    bus.i_id_use_rt   = urt;
    bus.i_id_rd       = AW'(rd);
    bus.i_id_regwrite = rw;
    bus.i_id_memread  = mr;
  endtask

  task automatic set_nop();
    bus.i_id_valid    = 1'b0;
    bus.i_id_rs       = '0;
    bus.i_id_rt       = '0;
    bus.i_id_use_rs   = 1'b0;
    bus.i_id_use_rt   = 1'b0;
    bus.i_id_rd       = '0;
    bus.i_id_regwrite = 1'b0;
    bus.i_id_memread  = 1'b0;
  endtask

  task automatic nops(input int n);
    set_nop();
    repeat (n) step();
  endtask

  // ---------------- behavioural model ----------------
  // Instructions in flight, index 0 = EX, 1 = MEM, 2 = WB.
  logic [AW-1:0] p_rd[3];
  bit            p_rw[3];
  bit            p_mr[3];
  logic [1:0]    m_fa, m_fb;
  int            m_cnt;
  bit            m_stalled;   // last un-halted edge inserted a load-use bubble
  logic [W-1:0]  exp_q[$];

  function automatic logic [1:0] m_sel(input bit u, input logic [AW-1:0] s);
    for (int k = 0; k < 2; k++)
      if (u && s != 0 && p_rw[k] && p_rd[k] == s) return (k == 0) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    bit needs;
    needs = (bus.i_id_use_rs && bus.i_id_rs == p_rd[0]) ||
            (bus.i_id_use_rt && bus.i_id_rt == p_rd[0]);
    return bus.i_id_valid && !bus.i_flush && !bus.i_halt && !m_stalled &&
           p_mr[0] && p_rw[0] && p_rd[0] != 0 && needs;
  endfunction

  always @(posedge clk) begin : model
    bit st, bub;
    logic [1:0] fa, fb;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin p_rd[k] = '0; p_rw[k] = 0; p_mr[k] = 0; end
      m_fa = 2'b00; m_fb = 2'b00; m_cnt = 0; m_stalled = 0;
    end else if (!bus.i_halt) begin
      st  = m_stall();
      bub = st || bus.i_flush || !bus.i_id_valid;
      fa  = bub ? 2'b00 : m_sel(bus.i_id_use_rs, bus.i_id_rs);
      fb  = bub ? 2'b00 : m_sel(bus.i_id_use_rt, bus.i_id_rt);
      p_rd[2] = p_rd[1]; p_rw[2] = p_rw[1]; p_mr[2] = p_mr[1];
      p_rd[1] = p_rd[0]; p_rw[1] = p_rw[0]; p_mr[1] = p_mr[0];
      p_rd[0] = bub ? '0 : bus.i_id_rd;
      p_rw[0] = bub ? 0 : bus.i_id_regwrite;
      p_mr[0] = bub ? 0 : bus.i_id_memread;
      m_fa = fa; m_fb = fb;
      if (st && m_cnt < CMAX) m_cnt++;
      m_stalled = st;
    end
    exp_q.push_back({m_fa, m_fb, CW'(m_cnt)});
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin : compare
    logic [W-1:0] e;
    bit es;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      es = m_stall();
      chk("fwd_a",  32'(bus.o_fwd_a), 32'(e[W-1 -: 2]));
      chk("fwd_b",  32'(bus.o_fwd_b), 32'(e[W-3 -: 2]));
      chk("count",  32'(bus.o_stall_count), 32'(e[CW-1:0]));
      chk("stall",  32'(bus.o_stall), 32'(es));
      chk("bubble", 32'(bus.o_bubble), 32'(es));
      chk("state",  32'(bus.dbg_state), 32'(m_stalled));
      chk("wb_rw",  32'(bus.dbg_wb_regwrite), 32'(p_rw[2]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.i_halt  = 1'b0;
    bus.i_flush = 1'b0;
    set_nop();
    rst = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("rst_fwd_a", 32'(bus.o_fwd_a), 0);
    chk("rst_stall", 32'(bus.o_stall), 0);
    chk("rst_count", 32'(bus.o_stall_count), 0);
    rst = 1'b0;
    step();

    // 1: add r3 in EX, sub r4,r3,r5 in ID
    nops(3);
    set_id(1, 2, 1, 1, 3, 1, 0); step();
    set_id(3, 5, 1, 1, 4, 1, 0);
    @(negedge clk); chk("s1_stall", 32'(bus.o_stall), 0);
    step(); set_nop();
    @(negedge clk); chk("s1_fwd_a", 32'(bus.o_fwd_a), 2); chk("s1_fwd_b", 32'(bus.o_fwd_b), 0);

    // 2: add r3; nop; or r6,r5,r3
    nops(3);
    set_id(1, 2, 1, 1, 3, 1, 0); step();
    set_nop(); step();
    set_id(5, 3, 1, 1, 6, 1, 0); step(); set_nop();
    @(negedge clk); chk("s2_fwd_a", 32'(bus.o_fwd_a), 0); chk("s2_fwd_b", 32'(bus.o_fwd_b), 1);
    // producers of r3 in both EX and MEM
    nops(3);
    set_id(1, 2, 1, 1, 3, 1, 0); step();
    set_id(1, 2, 1, 1, 3, 1, 0); step();
    set_id(3, 0, 1, 0, 8, 1, 0); step(); set_nop();
    @(negedge clk); chk("s2_nearest", 32'(bus.o_fwd_a), 2);

    // 3: lw r2; add r7,r2,r2
    nops(3);
    set_id(1, 0, 1, 0, 2, 1, 1); step();
    set_id(2, 2, 1, 1, 7, 1, 0);
    @(negedge clk); chk("s3_stall", 32'(bus.o_stall), 1); chk("s3_bubble", 32'(bus.o_bubble), 1);
    step();
    @(negedge clk); chk("s3_stall2", 32'(bus.o_stall), 0);
    step(); set_nop();
    @(negedge clk);
    chk("s3_fwd_a", 32'(bus.o_fwd_a), 1); chk("s3_fwd_b", 32'(bus.o_fwd_b), 1);
    chk("s3_count", 32'(bus.o_stall_count), 1);

    // 4: flush beats load-use; r0 never forwarded
    nops(3);
    set_id(1, 0, 1, 0, 2, 1, 1); step();
    set_id(2, 2, 1, 1, 7, 1, 0); bus.i_flush = 1'b1;
    @(negedge clk); chk("s4_stall", 32'(bus.o_stall), 0);
    step(); bus.i_flush = 1'b0; set_nop();
    @(negedge clk); chk("s4_count", 32'(bus.o_stall_count), 1); chk("s4_fwd_a", 32'(bus.o_fwd_a), 0);
    nops(3);
    set_id(1, 2, 1, 1, 0, 1, 0); step();
    set_id(0, 0, 1, 1, 4, 1, 0); step(); set_nop();
    @(negedge clk); chk("s4_r0_a", 32'(bus.o_fwd_a), 0); chk("s4_r0_b", 32'(bus.o_fwd_b), 0);
    nops(3);
    set_id(1, 0, 1, 0, 0, 1, 1); step();
    set_id(0, 0, 1, 1, 4, 1, 0);
    @(negedge clk); chk("s4_r0_load", 32'(bus.o_stall), 0);

    // 5: halt for 3 cycles during a load-use
    nops(3);
    set_id(1, 0, 1, 0, 2, 1, 1); step();
    set_id(2, 2, 1, 1, 7, 1, 0); bus.i_halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s5_halt_stall", 32'(bus.o_stall), 0);
      chk("s5_halt_count", 32'(bus.o_stall_count), 1);
      step();
    end
    bus.i_halt = 1'b0;
    @(negedge clk); chk("s5_stall", 32'(bus.o_stall), 1);
    step();
    @(negedge clk); chk("s5_stall2", 32'(bus.o_stall), 0);
    step(); set_nop();
    @(negedge clk);
    chk("s5_fwd_a", 32'(bus.o_fwd_a), 1); chk("s5_fwd_b", 32'(bus.o_fwd_b), 1);
    chk("s5_count", 32'(bus.o_stall_count), 2);

    // 6: reset while in LU_STALL, then saturate the counter
    nops(3);
    set_id(1, 0, 1, 0, 2, 1, 1); step();
    set_id(2, 2, 1, 1, 7, 1, 0);
    @(negedge clk); chk("s6_stall", 32'(bus.o_stall), 1);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    @(negedge clk);
    chk("s6_rst_stall", 32'(bus.o_stall), 0); chk("s6_rst_state", 32'(bus.dbg_state), 0);
    chk("s6_rst_count", 32'(bus.o_stall_count), 0); chk("s6_rst_fwd", 32'(bus.o_fwd_a), 0);
    step();
    for (int i = 0; i < CMAX + 2; i++) begin
      set_id(1, 0, 1, 0, 2, 1, 1); step();
      set_id(2, 2, 1, 1, 7, 1, 0); step(); step();
    end
    set_nop();
    @(negedge clk); chk("s6_saturate", 32'(bus.o_stall_count), CMAX);

    // Randomized traffic with small register space to force collisions
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      bus.i_halt  = ($urandom_range(0, 9) == 0);
      bus.i_flush = ($urandom_range(0, 9) == 0);
      set_id($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 2) == 0));
      bus.i_id_valid = ($urandom_range(0, 6) != 0);
      step();
    end
    rst = 1'b0; bus.i_halt = 1'b0; bus.i_flush = 1'b0; set_nop();
    repeat (2) step();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
